s_bus_sequencer: RTL and testbench

//  Upstream pacer for the SPC700 controller/datapath: generates the cpu_en strobe once per SPC700 bus cycle.

---
 rtl/s_bus_sequencer_if.sv | 32 +++
 rtl/s_bus_sequencer.sv | 109 ++++++++++
 tb/tb_s_bus_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s_bus_sequencer_if.sv
// Signal bundle between the SPC700 bus sequencer and its surroundings:
// CPU-side bus, IPL ROM lookup port and ARAM port.
interface s_bus_sequencer_if;
  logic        halt;
  logic        opfetch;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [7:0]  op;
  logic        cpu_en;
  logic        iplrom_en;
  logic [5:0]  ipl_addr;
  logic [7:0]  ipl_rdata;
  logic        dsp_busy;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_rd;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  // The sequencer drives the bus cycles, so it takes the master side.
  modport master (
    input  halt, opfetch, cpu_we, cpu_addr, cpu_wdata, iplrom_en, ipl_rdata, dsp_busy, ram_rdata,
    output cpu_rdata, op, cpu_en, ipl_addr, ram_addr, ram_wdata, ram_rd, ram_we
  );

  modport slave (
    output halt, opfetch, cpu_we, cpu_addr, cpu_wdata, iplrom_en, ipl_rdata, dsp_busy, ram_rdata,
    input  cpu_rdata, op, cpu_en, ipl_addr, ram_addr, ram_wdata, ram_rd, ram_we
  );
endinterface

// File: rtl/s_bus_sequencer.sv
// SPC700 bus sequencer: one cpu_en per bus cycle, one ARAM access per cycle
// around DSP slots, IPL ROM overlay on reads, and the fetched-opcode latch.
module s_bus_sequencer #(
  parameter int CLK_DIV = 24,
  parameter int RAM_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  s_bus_sequencer_if.master  bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_WAIT_SLOT = 3'd2;
  localparam logic [2:0] S_LAT       = 3'd3;
  localparam logic [2:0] S_DATA      = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam int PW = $clog2(CLK_DIV);
  localparam int LW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [LW-1:0] LAT_LAST   = LW'(RAM_LAT - 1);

  logic [2:0]    state;
  logic [PW-1:0] phase;
  logic [LW-1:0] lat_cnt;
  logic          cyc_we;
  logic          ipl_hit;
  logic          ipl_hit_now;
  logic          wait_hold;

  // Writes into $FFC0-$FFFF always go to ARAM; only reads see the ROM.
  assign ipl_hit_now  = bus.iplrom_en && !bus.cpu_we && (bus.cpu_addr >= 16'hFFC0);
  assign wait_hold    = (state == S_WAIT_SLOT) && bus.dsp_busy;
  assign bus.ipl_addr = bus.ram_addr[5:0];

  // Each clk the DSP keeps the slot stretches the bus cycle by one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (!wait_hold) begin
      phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      lat_cnt       <= '0;
      cyc_we        <= 1'b0;
      ipl_hit       <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.ram_rd    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.cpu_en    <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      // NOTE: strobes default low every clk so each one is exactly one clk wide.
      bus.ram_rd <= 1'b0;
      bus.ram_we <= 1'b0;
      bus.cpu_en <= 1'b0;
      case (state)
        S_IDLE: if (phase == '0) state <= S_ADDR;
        S_ADDR: begin
          bus.ram_addr  <= bus.cpu_addr;
          bus.ram_wdata <= bus.cpu_wdata;
          cyc_we        <= bus.cpu_we;
          ipl_hit       <= ipl_hit_now;
          state         <= ipl_hit_now ? S_DATA : S_WAIT_SLOT;
        end
        S_WAIT_SLOT: if (!bus.dsp_busy) begin
          if (cyc_we) begin
            bus.ram_we <= 1'b1;
            state      <= S_DONE;
          end else begin
            bus.ram_rd <= 1'b1;
            lat_cnt    <= '0;
            state      <= S_LAT;
          end
        end
        S_LAT: begin
          if (lat_cnt == LAT_LAST) state <= S_DATA;
          else                     lat_cnt <= lat_cnt + 1'b1;
        end
        S_DATA: begin
          bus.cpu_rdata <= ipl_hit ? bus.ipl_rdata : bus.ram_rdata;
          state         <= S_DONE;
        end
        S_DONE: if (phase == PHASE_LAST) begin
          // Halt only masks the strobe; the cycle itself still completes.
          bus.cpu_en <= !bus.halt;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The controller sees the new opcode in the clk after cpu_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.op <= '0;
    end else if (bus.cpu_en && bus.opfetch && !cyc_we) begin
      bus.op <= bus.cpu_rdata;
    end
  end

endmodule

// File: tb/tb_s_bus_sequencer.sv
// Scenario bench for s_bus_sequencer: latency-modelled ARAM, IPL ROM table,
// and a queue of expected cpu_rdata values popped at each cpu_en.
module tb_s_bus_sequencer;
  localparam int CLK_DIV = 24;
  localparam int RAM_LAT = 2;

  logic clk;
  logic reset;
  s_bus_sequencer_if bus ();

  s_bus_sequencer #(.CLK_DIV(CLK_DIV), .RAM_LAT(RAM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         checks = 0;
  int         passed = 0;
  logic [7:0] sb[$];

  int          rd_cnt = 0, we_cnt = 0, en_cnt = 0, overlap_cnt = 0, busy_strobe_cnt = 0;
  logic [15:0] we_addr = '0;
  logic [7:0]  we_data = '0;

  // ARAM model: unwritten locations return a fixed pattern; reads take RAM_LAT clks.
  logic [7:0] mem [logic [15:0]];
  logic [7:0] rd_s0, rd_s1;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    case (a)
      16'h0200: return 8'h5A;
      16'h0201: return 8'h96;
      16'h1234: return 8'hC3;
      16'h0300: return 8'hA5;
      16'h0400: return 8'h3C;
      16'h0500: return 8'hE7;
      16'hFFC0: return 8'h77;
      default:  return a[7:0] ^ a[15:8];
    endcase
  endfunction

  function automatic logic [7:0] read_mem(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : init_val(a);
  endfunction

  function automatic logic [7:0] ipl_val(input logic [5:0] i);
    return (i == 6'd0) ? 8'hCD : {2'b10, i};
  endfunction

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
    if (bus.ram_rd) rd_s0 <= read_mem(bus.ram_addr);
    rd_s1 <= rd_s0;
  end

  assign bus.ram_rdata = rd_s1;
  assign bus.ipl_rdata = ipl_val(bus.ipl_addr);

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ram_rd) rd_cnt++;
      if (bus.ram_we) begin
        we_cnt++;
        we_addr = bus.ram_addr;
        we_data = bus.ram_wdata;
      end
      if (bus.cpu_en) en_cnt++;
      if (bus.ram_rd && bus.ram_we) overlap_cnt++;
      if ((bus.ram_rd || bus.ram_we) && bus.dsp_busy) busy_strobe_cnt++;
    end
  end

  task automatic drive(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                       input logic fetch);
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.opfetch   = fetch;
  endtask

  // Counts clks until cpu_en is seen, then steps just past the following edge.
  task automatic wait_en(input int bound, output int len, output bit ok);
    len = 0;
    ok  = 1'b0;
    while (len < bound && !ok) begin
      @(negedge clk);
      len++;
      if (bus.cpu_en) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int len; bit ok; int rd0; logic [7:0] exp;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.cpu_en !== 1'b0) $display("FAIL reset_cpu_en: got %b expected 0", bus.cpu_en); else passed++;
    checks++; if (bus.ram_rd !== 1'b0) $display("FAIL reset_ram_rd: got %b expected 0", bus.ram_rd); else passed++;
    checks++; if (bus.ram_we !== 1'b0) $display("FAIL reset_ram_we: got %b expected 0", bus.ram_we); else passed++;
    checks++; if (bus.cpu_rdata !== 8'h00) $display("FAIL reset_cpu_rdata: got %h expected 00", bus.cpu_rdata); else passed++;
    checks++; if (bus.op !== 8'h00) $display("FAIL reset_op: got %h expected 00", bus.op); else passed++;
    drive(1'b0, 16'h0200, 8'h00, 1'b0);
    sb.push_back(8'h5A);
    rd0 = rd_cnt;
    reset = 1'b0;
    wait_en(100, len, ok);
    checks++; if (len !== CLK_DIV) $display("FAIL first_cycle_len: got %0d expected %0d", len, CLK_DIV); else passed++;
    exp = sb.pop_front();
    checks++; if (bus.cpu_rdata !== exp) $display("FAIL read_0200_data: got %h expected %h", bus.cpu_rdata, exp); else passed++;
    checks++; if (rd_cnt - rd0 !== 1) $display("FAIL read_0200_rd_count: got %0d expected 1", rd_cnt - rd0); else passed++;
  endtask

  task automatic test_back_to_back();
    int len; bit ok; int rd0; logic [7:0] exp; logic [15:0] addr;
    for (int i = 0; i < 2; i++) begin
      addr = (i == 0) ? 16'h1234 : 16'h0201;
      drive(1'b0, addr, 8'h00, 1'b0);
      sb.push_back((i == 0) ? 8'hC3 : 8'h96);
      rd0 = rd_cnt;
      wait_en(100, len, ok);
      checks++; if (len !== CLK_DIV) $display("FAIL b2b_len_%0d: got %0d expected %0d", i, len, CLK_DIV); else passed++;
      exp = sb.pop_front();
      checks++; if (bus.cpu_rdata !== exp) $display("FAIL b2b_data_%0d: got %h expected %h", i, bus.cpu_rdata, exp); else passed++;
      checks++; if (rd_cnt - rd0 !== 1) $display("FAIL b2b_rd_count_%0d: got %0d expected 1", i, rd_cnt - rd0); else passed++;
    end
  endtask

  task automatic test_ipl();
    int len; bit ok; int rd0; logic [7:0] exp;
    for (int i = 0; i < 2; i++) begin
      bus.iplrom_en = (i == 0);
      drive(1'b0, 16'hFFC0, 8'h00, 1'b1);
      sb.push_back((i == 0) ? 8'hCD : 8'h77);
      rd0 = rd_cnt;
      wait_en(100, len, ok);
      exp = sb.pop_front();
      checks++; if (bus.cpu_rdata !== exp) $display("FAIL ipl_data_en%0d: got %h expected %h", 1 - i, bus.cpu_rdata, exp); else passed++;
      checks++; if (bus.op !== exp) $display("FAIL ipl_op_en%0d: got %h expected %h", 1 - i, bus.op, exp); else passed++;
      checks++; if (rd_cnt - rd0 !== i) $display("FAIL ipl_rd_count_en%0d: got %0d expected %0d", 1 - i, rd_cnt - rd0, i); else passed++;
      checks++; if (len !== CLK_DIV) $display("FAIL ipl_len_en%0d: got %0d expected %0d", 1 - i, len, CLK_DIV); else passed++;
    end
  endtask

  task automatic test_write();
    int len; bit ok; int rd0, we0; logic [7:0] exp;
    bus.iplrom_en = 1'b1;
    drive(1'b1, 16'hFFC5, 8'h11, 1'b0);
    rd0 = rd_cnt;
    we0 = we_cnt;
    fork
      begin
        @(posedge clk);
        #1;
        drive(1'b0, 16'h0000, 8'hFF, 1'b0);
      end
      wait_en(100, len, ok);
    join
    checks++; if (len !== CLK_DIV) $display("FAIL write_len: got %0d expected %0d", len, CLK_DIV); else passed++;
    checks++; if (we_cnt - we0 !== 1) $display("FAIL write_we_count: got %0d expected 1", we_cnt - we0); else passed++;
    checks++; if (rd_cnt - rd0 !== 0) $display("FAIL write_rd_count: got %0d expected 0", rd_cnt - rd0); else passed++;
    checks++; if (we_addr !== 16'hFFC5) $display("FAIL write_addr: got %h expected FFC5", we_addr); else passed++;
    checks++; if (we_data !== 8'h11) $display("FAIL write_data: got %h expected 11", we_data); else passed++;
    bus.iplrom_en = 1'b0;
    drive(1'b0, 16'hFFC5, 8'h00, 1'b0);
    sb.push_back(8'h11);
    wait_en(100, len, ok);
    exp = sb.pop_front();
    checks++; if (bus.cpu_rdata !== exp) $display("FAIL write_readback: got %h expected %h", bus.cpu_rdata, exp); else passed++;
  endtask

  task automatic test_dsp_busy();
    int len; bit ok; int rd0, bs0; logic [7:0] exp;
    drive(1'b0, 16'h0300, 8'h00, 1'b0);
    sb.push_back(8'hA5);
    rd0 = rd_cnt;
    bs0 = busy_strobe_cnt;
    bus.dsp_busy = 1'b1;
    fork
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.dsp_busy = 1'b0;
      end
      wait_en(100, len, ok);
    join
    checks++; if (len !== CLK_DIV + 5) $display("FAIL busy_len: got %0d expected %0d", len, CLK_DIV + 5); else passed++;
    exp = sb.pop_front();
    checks++; if (bus.cpu_rdata !== exp) $display("FAIL busy_data: got %h expected %h", bus.cpu_rdata, exp); else passed++;
    checks++; if (rd_cnt - rd0 !== 1) $display("FAIL busy_rd_count: got %0d expected 1", rd_cnt - rd0); else passed++;
    checks++; if (busy_strobe_cnt - bs0 !== 0) $display("FAIL busy_strobe: got %0d expected 0", busy_strobe_cnt - bs0); else passed++;
  endtask

  task automatic test_halt();
    int len; bit ok; int rd0, en0; logic [7:0] exp;
    drive(1'b0, 16'h0400, 8'h00, 1'b0);
    sb.push_back(8'h3C);
    rd0 = rd_cnt;
    en0 = en_cnt;
    bus.halt = 1'b1;
    fork
      begin
        repeat (30) @(posedge clk);
        #1;
        checks++; if (bus.cpu_rdata !== 8'h3C) $display("FAIL halt_rdata_update: got %h expected 3C", bus.cpu_rdata); else passed++;
        repeat (50) @(posedge clk);
        #1;
        bus.halt = 1'b0;
      end
      wait_en(200, len, ok);
    join
    checks++; if (len !== 4 * CLK_DIV) $display("FAIL halt_resume_len: got %0d expected %0d", len, 4 * CLK_DIV); else passed++;
    checks++; if (en_cnt - en0 !== 1) $display("FAIL halt_en_count: got %0d expected 1", en_cnt - en0); else passed++;
    checks++; if (rd_cnt - rd0 !== 4) $display("FAIL halt_rd_count: got %0d expected 4", rd_cnt - rd0); else passed++;
    exp = sb.pop_front();
    checks++; if (bus.cpu_rdata !== exp) $display("FAIL halt_data: got %h expected %h", bus.cpu_rdata, exp); else passed++;
  endtask

  task automatic test_reset_mid();
    int len; bit ok; int n; bit seen; logic [7:0] exp;
    drive(1'b0, 16'h0200, 8'h00, 1'b1);
    sb.push_back(8'h5A);
    n = 0;
    seen = 1'b0;
    while (n < 40 && !seen) begin
      @(negedge clk);
      n++;
      if (bus.ram_rd) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) $display("FAIL mid_reset_rd_seen: got %b expected 1", seen); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (bus.ram_rd !== 1'b0) $display("FAIL mid_reset_ram_rd: got %b expected 0", bus.ram_rd); else passed++;
    checks++; if (bus.ram_we !== 1'b0) $display("FAIL mid_reset_ram_we: got %b expected 0", bus.ram_we); else passed++;
    checks++; if (bus.cpu_en !== 1'b0) $display("FAIL mid_reset_cpu_en: got %b expected 0", bus.cpu_en); else passed++;
    checks++; if (bus.op !== 8'h00) $display("FAIL mid_reset_op: got %h expected 00", bus.op); else passed++;
    checks++; if (bus.cpu_rdata !== 8'h00) $display("FAIL mid_reset_rdata: got %h expected 00", bus.cpu_rdata); else passed++;
    sb.delete();
    repeat (2) @(negedge clk);
    drive(1'b0, 16'h0500, 8'h00, 1'b1);
    sb.push_back(8'hE7);
    reset = 1'b0;
    wait_en(100, len, ok);
    checks++; if (len !== CLK_DIV) $display("FAIL post_reset_len: got %0d expected %0d", len, CLK_DIV); else passed++;
    exp = sb.pop_front();
    checks++; if (bus.cpu_rdata !== exp) $display("FAIL post_reset_data: got %h expected %h", bus.cpu_rdata, exp); else passed++;
    checks++; if (bus.op !== exp) $display("FAIL post_reset_op: got %h expected %h", bus.op, exp); else passed++;
  endtask

  task automatic test_invariants();
    checks++; if (overlap_cnt !== 0) $display("FAIL rd_we_overlap: got %0d expected 0", overlap_cnt); else passed++;
    checks++; if (busy_strobe_cnt !== 0) $display("FAIL strobe_while_busy: got %0d expected 0", busy_strobe_cnt); else passed++;
  endtask

  initial begin
    reset         = 1'b1;
    bus.halt      = 1'b0;
    bus.dsp_busy  = 1'b0;
    bus.iplrom_en = 1'b0;
    drive(1'b0, 16'h0000, 8'h00, 1'b0);
    test_reset();
    test_back_to_back();
    test_ipl();
    test_write();
    test_dsp_busy();
    test_halt();
    test_reset_mid();
    test_invariants();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
